// File: rtl/fpu_mult_pkg.sv
// Shared definitions for the FP multiplier dispatch slice: FSM state encoding,
// round-mode codes and default sizing.
package fpu_mult_pkg;

    localparam int FPU_W_DEF       = 32;
    localparam int FPU_DEPTH_DEF   = 4;
    localparam int FPU_TIMEOUT_DEF = 255;
    localparam int FPU_TO_W_DEF    = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_FLUSH = 3'd4
    } disp_state_e;

    localparam logic [1:0] RND_NEAREST = 2'b00;
    localparam logic [1:0] RND_POS_INF = 2'b01;
    localparam logic [1:0] RND_NEG_INF = 2'b10;
    localparam logic [1:0] RND_ZERO    = 2'b11;

endpackage

// File: rtl/fpu_op_fifo.sv
// Small synchronous FIFO holding {round, y, x} operand bundles ahead of the
// multiplier. Pointers carry one extra wrap bit to tell full from empty.
module fpu_op_fifo #(
    parameter int DW    = 66,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] dout
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          w_push;
    logic          w_pop;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign dout  = r_mem[r_rd_ptr[AW-1:0]];

    // A pop frees the head slot in the same cycle, so a push into a full FIFO is fine then.
    assign w_pop  = pop & ~empty;
    assign w_push = push & (~full | w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/fpu_mult_dispatch.sv
// Issue stage for the FP multiplier: operand FIFO, one-at-a-time handshake FSM,
// watchdog and result register. Optional sticky flags under FPU_DISPATCH_STICKY_EN.
module fpu_mult_dispatch
    import fpu_mult_pkg::*;
#(
    parameter int W       = FPU_W_DEF,
    parameter int DEPTH   = FPU_DEPTH_DEF,
    parameter int TIMEOUT = FPU_TIMEOUT_DEF,
    parameter int TO_W    = FPU_TO_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_x,
    input  logic [W-1:0] in_y,
    input  logic [1:0]   in_round,
    output logic         mult_beg,
    output logic         mult_rst_fsm,
    output logic [W-1:0] mult_x,
    output logic [W-1:0] mult_y,
    output logic [1:0]   mult_round,
    input  logic         mult_ready,
    input  logic [W-1:0] mult_result,
    input  logic         mult_ovf,
    input  logic         mult_unf,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_result,
    output logic         out_ovf,
    output logic         out_unf,
    output logic         out_timeout,
`ifdef FPU_DISPATCH_STICKY_EN
    input  logic         sticky_clr,
    output logic         sticky_ovf,
    output logic         sticky_unf,
    output logic         sticky_to,
`endif
    output logic         busy
);
    localparam int              DW       = 2 * W + 2;
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);

    disp_state_e     r_state;
    logic [W-1:0]    r_op_x;
    logic [W-1:0]    r_op_y;
    logic [1:0]      r_op_round;
    logic            r_mult_beg;
    logic            r_mult_rst_fsm;
    logic [TO_W-1:0] r_wd_cnt;
    logic            r_flush_cnt;
    logic            r_out_valid;
    logic [W-1:0]    r_out_result;
    logic            r_out_ovf;
    logic            r_out_unf;
    logic            r_out_timeout;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic [DW-1:0]   w_fifo_dout;
    logic            w_wait_ready;
    logic            w_wait_expire;

    assign w_push = in_valid & ~w_full;
    // Never issue while a result is still waiting for the consumer.
    assign w_pop  = (r_state == ST_IDLE) & ~w_empty & ~r_out_valid;

    assign w_wait_ready  = (r_state == ST_WAIT) & mult_ready;
    assign w_wait_expire = (r_state == ST_WAIT) & ~mult_ready & (r_wd_cnt == TO_LIMIT);

    fpu_op_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   ({in_round, in_y, in_x}),
        .full  (w_full),
        .empty (w_empty),
        .dout  (w_fifo_dout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_op_x         <= '0;
            r_op_y         <= '0;
            r_op_round     <= '0;
            r_mult_beg     <= 1'b0;
            r_mult_rst_fsm <= 1'b0;
            r_wd_cnt       <= '0;
            r_flush_cnt    <= 1'b0;
            r_out_valid    <= 1'b0;
            r_out_result   <= '0;
            r_out_ovf      <= 1'b0;
            r_out_unf      <= 1'b0;
            r_out_timeout  <= 1'b0;
        end else begin
            r_mult_beg     <= 1'b0;
            r_mult_rst_fsm <= 1'b0;
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        {r_op_round, r_op_y, r_op_x} <= w_fifo_dout;
                        r_mult_beg <= 1'b1;
                        r_state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_wd_cnt <= '0;
                    r_state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Ready is checked first so it wins over a simultaneous expiry.
                    if (w_wait_ready) begin
                        r_out_result   <= mult_result;
                        r_out_ovf      <= mult_ovf;
                        r_out_unf      <= mult_unf;
                        r_out_timeout  <= 1'b0;
                        r_out_valid    <= 1'b1;
                        r_mult_rst_fsm <= 1'b1;
                        r_state        <= ST_DONE;
                    end else if (w_wait_expire) begin
                        r_out_result   <= '0;
                        r_out_ovf      <= 1'b0;
                        r_out_unf      <= 1'b0;
                        r_out_timeout  <= 1'b1;
                        r_out_valid    <= 1'b1;
                        r_mult_rst_fsm <= 1'b1;
                        r_state        <= ST_DONE;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + TO_W'(1);
                    end
                end
                ST_DONE: begin
                    r_flush_cnt <= 1'b0;
                    r_state     <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    // Give the multiplier two cycles to drop ready, then move on anyway.
                    if (!mult_ready || r_flush_cnt) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_flush_cnt <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef FPU_DISPATCH_STICKY_EN
    logic r_sticky_ovf;
    logic r_sticky_unf;
    logic r_sticky_to;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sticky_ovf <= 1'b0;
            r_sticky_unf <= 1'b0;
            r_sticky_to  <= 1'b0;
        end else begin
            r_sticky_ovf <= (r_sticky_ovf & ~sticky_clr) | (w_wait_ready & mult_ovf);
            r_sticky_unf <= (r_sticky_unf & ~sticky_clr) | (w_wait_ready & mult_unf);
            r_sticky_to  <= (r_sticky_to  & ~sticky_clr) | w_wait_expire;
        end
    end

    assign sticky_ovf = r_sticky_ovf;
    assign sticky_unf = r_sticky_unf;
    assign sticky_to  = r_sticky_to;
`endif

    assign in_ready     = ~w_full;
    assign mult_beg     = r_mult_beg;
    assign mult_rst_fsm = r_mult_rst_fsm;
    assign mult_x       = r_op_x;
    assign mult_y       = r_op_y;
    assign mult_round   = r_op_round;
    assign out_valid    = r_out_valid;
    assign out_result   = r_out_result;
    assign out_ovf      = r_out_ovf;
    assign out_unf      = r_out_unf;
    assign out_timeout  = r_out_timeout;
    assign busy         = (r_state != ST_IDLE) | ~w_empty;

endmodule

// File: tb/tb_fpu_mult_dispatch.sv
// Directed bench for fpu_mult_dispatch with a latency-programmable multiplier model.
// Sticky-flag checks are compiled in when FPU_DISPATCH_STICKY_EN is defined.
module tb_fpu_mult_dispatch;
    localparam int W  = 32;
    localparam int NV = 9;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [1:0]  rnd;
        logic [31:0] res;
        logic        ovf;
        logic        unf;
    } vec_t;

    vec_t vecs[NV];

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_x;
    logic [W-1:0] in_y;
    logic [1:0]   in_round;
    logic         mult_beg;
    logic         mult_rst_fsm;
    logic [W-1:0] mult_x;
    logic [W-1:0] mult_y;
    logic [1:0]   mult_round;
    logic         mult_ready;
    logic [W-1:0] mult_result;
    logic         mult_ovf;
    logic         mult_unf;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_ovf;
    logic         out_unf;
    logic         out_timeout;
    logic         busy;
`ifdef FPU_DISPATCH_STICKY_EN
    logic         sticky_clr;
    logic         sticky_ovf;
    logic         sticky_unf;
    logic         sticky_to;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int n_pushed = 0;
    int stall_seen = 0;
    int stall_after = 0;
    int beg_cnt = 0;
    int rstf_cnt = 0;
    int m_lat = 6;
    bit m_hang = 1'b0;
    bit m_run;
    int m_cnt;

    always #5 clk = ~clk;

    fpu_mult_dispatch #(
        .W       (W),
        .DEPTH   (4),
        .TIMEOUT (16),
        .TO_W    (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_x         (in_x),
        .in_y         (in_y),
        .in_round     (in_round),
        .mult_beg     (mult_beg),
        .mult_rst_fsm (mult_rst_fsm),
        .mult_x       (mult_x),
        .mult_y       (mult_y),
        .mult_round   (mult_round),
        .mult_ready   (mult_ready),
        .mult_result  (mult_result),
        .mult_ovf     (mult_ovf),
        .mult_unf     (mult_unf),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_ovf      (out_ovf),
        .out_unf      (out_unf),
        .out_timeout  (out_timeout),
`ifdef FPU_DISPATCH_STICKY_EN
        .sticky_clr   (sticky_clr),
        .sticky_ovf   (sticky_ovf),
        .sticky_unf   (sticky_unf),
        .sticky_to    (sticky_to),
`endif
        .busy         (busy)
    );

    // Product lookup: only the hand-computed pairs (matched with their round mode) are known.
    function automatic logic [33:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                            input logic [1:0] r);
        logic [33:0] v;
        v = {2'b00, 32'hDEADBEEF};
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].x == x && vecs[i].y == y && vecs[i].rnd == r) begin
                v = {vecs[i].ovf, vecs[i].unf, vecs[i].res};
            end
        end
        return v;
    endfunction

    // Multiplier model: ready rises m_lat cycles after beg is sampled, drops on rst_FSM.
    always @(posedge clk) begin
        if (rst) begin
            mult_ready  <= 1'b0;
            mult_result <= '0;
            mult_ovf    <= 1'b0;
            mult_unf    <= 1'b0;
            m_run       <= 1'b0;
            m_cnt       <= 0;
        end else if (mult_rst_fsm) begin
            mult_ready <= 1'b0;
            m_run      <= 1'b0;
        end else if (mult_beg) begin
            mult_ready <= 1'b0;
            m_run      <= 1'b1;
            m_cnt      <= m_lat;
        end else if (m_run && !m_hang) begin
            if (m_cnt == 1) begin
                mult_ready <= 1'b1;
                m_run      <= 1'b0;
                {mult_ovf, mult_unf, mult_result} <= ref_mul(mult_x, mult_y, mult_round);
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    always @(posedge clk) begin
        if (mult_beg)     beg_cnt  <= beg_cnt + 1;
        if (mult_rst_fsm) rstf_cnt <= rstf_cnt + 1;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int i);
        int  t;
        bit  acc;
        t   = 0;
        acc = 1'b0;
        in_valid = 1'b1;
        in_x     = vecs[i].x;
        in_y     = vecs[i].y;
        in_round = vecs[i].rnd;
        while (!acc && t < 500) begin
            acc = in_ready;
            if (!acc && stall_seen == 0) begin
                stall_seen  = 1;
                stall_after = n_pushed;
            end
            tick();
            t++;
        end
        in_valid = 1'b0;
        if (acc) n_pushed++;
        else check("push_accept", 64'(acc), 64'd1);
    endtask

    task automatic collect(input int first, input int n);
        int got;
        int t;
        got = 0;
        t   = 0;
        while (got < n && t < 2000) begin
            if (out_valid && out_ready) begin
                $display("txn %0d: result=%08h ovf=%0b unf=%0b to=%0b", first + got,
                         out_result, out_ovf, out_unf, out_timeout);
                check("result", 64'(out_result), 64'(vecs[first+got].res));
                check("ovf", 64'(out_ovf), 64'(vecs[first+got].ovf));
                check("unf", 64'(out_unf), 64'(vecs[first+got].unf));
                check("timeout_flag", 64'(out_timeout), 64'd0);
                got++;
            end
            if (got < n) begin
                tick();
                t++;
            end
        end
        if (got < n) check("collect_count", 64'(got), 64'(n));
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((busy || out_valid) && t < 300) begin
            tick();
            t++;
        end
        check("idle_reached", 64'(busy || out_valid), 64'd0);
    endtask

    task automatic wait_out_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            tick();
            cyc++;
        end
        if (!out_valid) check("out_valid_wait", 64'(out_valid), 64'd1);
    endtask

    initial begin
        int cyc;
        int b0;
        int r0;
        bit hold_ok;
        logic [31:0] held;

        vecs[0] = '{32'h40000000, 32'h40400000, 2'b10, 32'h40C00000, 1'b0, 1'b0};
        vecs[1] = '{32'h3F800000, 32'h3F800000, 2'b00, 32'h3F800000, 1'b0, 1'b0};
        vecs[2] = '{32'h40000000, 32'h40000000, 2'b01, 32'h40800000, 1'b0, 1'b0};
        vecs[3] = '{32'h3FC00000, 32'h40000000, 2'b11, 32'h40400000, 1'b0, 1'b0};
        vecs[4] = '{32'h40800000, 32'h3F000000, 2'b00, 32'h40000000, 1'b0, 1'b0};
        vecs[5] = '{32'h40400000, 32'h40400000, 2'b10, 32'h41100000, 1'b0, 1'b0};
        vecs[6] = '{32'h3F000000, 32'h3F000000, 2'b01, 32'h3E800000, 1'b0, 1'b0};
        vecs[7] = '{32'h7F000000, 32'h7F000000, 2'b00, 32'h7F800000, 1'b1, 1'b0};
        vecs[8] = '{32'h00800000, 32'h00800000, 2'b11, 32'h00000000, 1'b0, 1'b1};

        rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; in_round = '0; out_ready = 1'b0;
`ifdef FPU_DISPATCH_STICKY_EN
        sticky_clr = 1'b0;
`endif
        repeat (3) tick();
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_beg", 64'({mult_beg, mult_rst_fsm}), 64'd0);
        check("rst_outs", 64'({out_result, out_ovf, out_unf, out_timeout}), 64'd0);
        check("rst_mult_x", 64'(mult_x), 64'd0);
        rst = 1'b0;
        tick();

        // Single op, latency 6: out_valid 9 cycles after the push edge.
        push(0);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            tick();
            cyc++;
            if (cyc == 1) check("beg_high", 64'(mult_beg), 64'd1);
            if (cyc == 2) check("beg_low", 64'(mult_beg), 64'd0);
            if (cyc == 4) check("mult_ops", 64'({mult_round, mult_x}), 64'({2'b10, 32'h40000000}));
            if (cyc == 4) check("mult_y", 64'(mult_y), 64'h40400000);
        end
        check("latency_t1", 64'(cyc), 64'd9);
        out_ready = 1'b1;
        collect(0, 1);
        wait_idle();

        // Back-to-back: six pairs, FIFO fills behind the one already issued.
        stall_seen = 0;
        n_pushed = 0;
        fork
            begin
                for (int i = 1; i <= 6; i++) push(i);
            end
            collect(1, 6);
        join
        check("stall_seen", 64'(stall_seen), 64'd1);
        check("stall_after", 64'(stall_after), 64'd5);
        wait_idle();

        // Backpressure: result held for 20 cycles with no new issue, then drains in order.
        out_ready = 1'b0;
        fork
            begin
                for (int i = 2; i <= 4; i++) push(i);
            end
            begin
                wait_out_valid(cyc);
                b0 = beg_cnt;
                held = out_result;
                hold_ok = 1'b1;
                repeat (20) begin
                    tick();
                    if (!out_valid || out_result !== held) hold_ok = 1'b0;
                end
                check("bp_no_beg", 64'(beg_cnt - b0), 64'd0);
                check("bp_hold", 64'(hold_ok), 64'd1);
                out_ready = 1'b1;
                collect(2, 3);
            end
        join
        wait_idle();

        // Overflow and underflow flags.
        push(7);
        push(8);
        collect(7, 2);
        wait_idle();
`ifdef FPU_DISPATCH_STICKY_EN
        check("sticky_ovf_set", 64'({sticky_ovf, sticky_unf, sticky_to}), 64'b110);
        sticky_clr = 1'b1;
        tick();
        sticky_clr = 1'b0;
        check("sticky_clr", 64'({sticky_ovf, sticky_unf, sticky_to}), 64'b000);
`endif

        // Watchdog: ready never comes, abort after TIMEOUT=16 -> 19 cycles from push.
        out_ready = 1'b0;
        m_hang = 1'b1;
        r0 = rstf_cnt;
        push(0);
        wait_out_valid(cyc);
        check("wd_latency", 64'(cyc), 64'd19);
        $display("txn wd: result=%08h timeout=%0b", out_result, out_timeout);
        check("wd_timeout", 64'(out_timeout), 64'd1);
        check("wd_result", 64'(out_result), 64'd0);
        m_hang = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        check("wd_rst_pulses", 64'(rstf_cnt - r0), 64'd1);
`ifdef FPU_DISPATCH_STICKY_EN
        check("sticky_to", 64'(sticky_to), 64'd1);
`endif
        push(5);
        collect(5, 1);
        wait_idle();

        // Reset while in WAIT: aborts with no output, next op completes.
        push(3);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rw_out_valid", 64'(out_valid), 64'd0);
        check("rw_in_ready", 64'(in_ready), 64'd1);
        check("rw_busy", 64'(busy), 64'd0);
        hold_ok = 1'b1;
        repeat (15) begin
            tick();
            if (out_valid) hold_ok = 1'b0;
        end
        check("rw_no_output", 64'(hold_ok), 64'd1);
        push(0);
        collect(0, 1);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
